// File: rtl/imem_arbiter_pkg.sv
// Shared constants, state encoding and address check for the instruction-memory
// arbiter.
package imem_pkg;

  localparam int DEPTH = 1024;
  localparam int AW    = $clog2(DEPTH);

  typedef enum logic [0:0] {
    BOOT = 1'b0,
    RUN  = 1'b1
  } state_t;

  // Word-aligned and inside the memory; anything else is a fault or a dropped write.
  function automatic logic addr_ok(input logic [31:0] addr);
    return (addr[1:0] == 2'b00) && (addr < 32'(4 * DEPTH));
  endfunction

endpackage

// File: rtl/imem_arbiter_if.sv
// Requester-side bus of the instruction-memory arbiter: IF fetch port, loader
// write port and the boot-done strobe.
interface imem_arbiter_if;

  logic        fetch_req;
  logic [31:0] fetch_addr;
  logic        fetch_gnt;
  logic        fetch_valid;
  logic [31:0] fetch_rdata;
  logic        fetch_fault;
  logic        ld_req;
  logic [31:0] ld_addr;
  logic [31:0] ld_wdata;
  logic        ld_gnt;
  logic        ld_done;

  modport master (
    output fetch_req, fetch_addr, ld_req, ld_addr, ld_wdata, ld_done,
    input  fetch_gnt, fetch_valid, fetch_rdata, fetch_fault, ld_gnt
  );

  modport slave (
    input  fetch_req, fetch_addr, ld_req, ld_addr, ld_wdata, ld_done,
    output fetch_gnt, fetch_valid, fetch_rdata, fetch_fault, ld_gnt
  );

endinterface

// File: rtl/imem_arbiter_starve_ctr.sv
// Counts consecutive cycles a loader request loses arbitration; raises
// force_win once the count reaches MAX_WAIT so the next grant goes to the loader.
module imem_starve_ctr #(
  parameter int MAX_WAIT = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic req,
  input  logic gnt,
  output logic force_win
);

  localparam int CW = 8;

  logic [CW-1:0] cnt_r;

  // Saturating loss counter, cleared whenever the request is idle or served.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_r <= {CW{1'b0}};
    end else if (!req || gnt) begin
      cnt_r <= {CW{1'b0}};
    end else if (cnt_r != CW'(MAX_WAIT)) begin
      cnt_r <= cnt_r + 8'd1;
    end else begin
      cnt_r <= cnt_r;
    end
  end

  assign force_win = (cnt_r == CW'(MAX_WAIT));

endmodule

// File: rtl/imem_arbiter.sv
// Single-port instruction-memory owner: boot sequencing, fetch/loader
// arbitration with starvation guard, and the one-cycle fetch read pipeline.
module imem_arbiter
  import imem_pkg::*;
#(
  parameter int MAX_WAIT = 8
) (
  input  logic              clk,
  input  logic              rst,
  imem_arbiter_if.slave     bus,
  output logic              core_rst_n,
  output logic              mem_en,
  output logic              mem_we,
  output logic [AW-1:0]     mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata
);

  state_t      state_r;
  state_t      state_nxt_s;
  logic        core_rst_n_r;
  logic        valid_r;
  logic        fault_r;
  logic        fetch_ok_s;
  logic        ld_ok_s;
  logic        fetch_gnt_s;
  logic        ld_gnt_s;
  logic        force_s;

  imem_starve_ctr #(
    .MAX_WAIT (MAX_WAIT)
  ) u_starve (
    .clk       (clk),
    .rst       (rst),
    .req       (bus.ld_req),
    .gnt       (ld_gnt_s),
    .force_win (force_s)
  );

  // Next state, grant selection and memory port drive.
  always_comb begin
    fetch_ok_s  = addr_ok(bus.fetch_addr);
    ld_ok_s     = addr_ok(bus.ld_addr);
    state_nxt_s = state_r;
    fetch_gnt_s = 1'b0;
    ld_gnt_s    = 1'b0;
    mem_en      = 1'b0;
    mem_we      = 1'b0;
    mem_addr    = {AW{1'b0}};
    mem_wdata   = 32'h0000_0000;
    case (state_r)
      BOOT: begin
        ld_gnt_s = bus.ld_req;
        if (bus.ld_done) begin
          state_nxt_s = RUN;
        end else begin
          state_nxt_s = BOOT;
        end
      end
      RUN: begin
        state_nxt_s = RUN;
        // Fetch has priority unless the loader has been starved long enough.
        if (bus.ld_req && (force_s || !bus.fetch_req)) begin
          ld_gnt_s = 1'b1;
        end else if (bus.fetch_req) begin
          fetch_gnt_s = 1'b1;
        end else begin
          fetch_gnt_s = 1'b0;
        end
      end
      default: begin
        state_nxt_s = BOOT;
      end
    endcase
    if (fetch_gnt_s && fetch_ok_s) begin
      mem_en   = 1'b1;
      mem_addr = bus.fetch_addr[AW+1:2];
    end else if (ld_gnt_s && ld_ok_s) begin
      mem_en    = 1'b1;
      mem_we    = 1'b1;
      mem_addr  = bus.ld_addr[AW+1:2];
      mem_wdata = bus.ld_wdata;
    end else begin
      mem_en = 1'b0;
    end
  end

  // State register, core reset release and read-pipeline flags.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r      <= BOOT;
      core_rst_n_r <= 1'b0;
      valid_r      <= 1'b0;
      fault_r      <= 1'b0;
    end else begin
      state_r      <= state_nxt_s;
      core_rst_n_r <= (state_r == RUN);
      valid_r      <= fetch_gnt_s;
      fault_r      <= fetch_gnt_s && !fetch_ok_s;
    end
  end

  assign bus.fetch_gnt   = fetch_gnt_s;
  assign bus.ld_gnt      = ld_gnt_s;
  assign bus.fetch_valid = valid_r;
  assign bus.fetch_fault = fault_r;
  // The macro's read data is only meaningful in the cycle after a real read.
  assign bus.fetch_rdata = (valid_r && !fault_r) ? mem_rdata : 32'h0000_0000;
  assign core_rst_n      = core_rst_n_r;

endmodule

// File: tb/tb_imem_arbiter.sv
// Self-checking bench for imem_arbiter: directed boot/fetch/fault/starvation/
// hazard/reset steps followed by randomized traffic against a reference model.
module tb_imem_arbiter;
  import imem_pkg::*;

  localparam int MAX_WAIT = 8;

  logic          clk;
  logic          rst;
  logic          core_rst_n;
  logic          mem_en;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [31:0]   mem_wdata;
  logic [31:0]   mem_rdata;

  imem_arbiter_if bus ();

  imem_arbiter #(
    .MAX_WAIT (MAX_WAIT)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .bus        (bus),
    .core_rst_n (core_rst_n),
    .mem_en     (mem_en),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_rdata  (mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Synchronous-read memory macro seen by the DUT.
  logic [31:0] macro [0:DEPTH-1];
  always @(posedge clk) begin
    if (mem_en) begin
      if (mem_we) macro[mem_addr] <= mem_wdata;
      else        mem_rdata <= macro[mem_addr];
    end
  end

  int checks = 0;
  int errors = 0;

  // Reference model state
  logic [31:0] golden [0:DEPTH-1];
  bit          m_run;
  int          m_wait;
  bit          m_core;
  bit          m_pv;
  bit          m_pf;
  logic [31:0] m_pd;
  bit          m_fg;
  bit          m_lg;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m_run = 1'b0; m_wait = 0; m_core = 1'b0;
    m_pv = 1'b0; m_pf = 1'b0; m_pd = 32'h0; m_fg = 1'b0; m_lg = 1'b0;
  endtask

  function automatic bit valid_addr(input logic [31:0] a);
    return (a % 4 == 0) && (a < 4 * DEPTH);
  endfunction

  // One clock cycle: check last cycle's registered results, drive, check grants.
  task automatic step(input bit fr, input logic [31:0] fa, input bit lr,
                      input logic [31:0] la, input logic [31:0] lw, input bit ld);
    bit          fok, lok, e_en, e_we;
    logic [31:0] e_addr;
    @(negedge clk);
    chk("fetch_valid", {31'd0, bus.fetch_valid}, {31'd0, m_pv});
    chk("fetch_fault", {31'd0, bus.fetch_fault}, {31'd0, m_pf});
    chk("fetch_rdata", bus.fetch_rdata, m_pd);
    chk("core_rst_n", {31'd0, core_rst_n}, {31'd0, m_core});
    bus.fetch_req = fr; bus.fetch_addr = fa;
    bus.ld_req = lr; bus.ld_addr = la; bus.ld_wdata = lw; bus.ld_done = ld;
    #1;
    fok = valid_addr(fa);
    lok = valid_addr(la);
    if (!m_run) begin
      m_lg = lr; m_fg = 1'b0;
    end else if (lr && (m_wait == MAX_WAIT || !fr)) begin
      m_lg = 1'b1; m_fg = 1'b0;
    end else begin
      m_lg = 1'b0; m_fg = fr;
    end
    e_en   = (m_fg && fok) || (m_lg && lok);
    e_we   = m_lg && lok;
    e_addr = !e_en ? 32'd0 : (m_fg ? fa / 4 : la / 4);
    chk("fetch_gnt", {31'd0, bus.fetch_gnt}, {31'd0, m_fg});
    chk("ld_gnt", {31'd0, bus.ld_gnt}, {31'd0, m_lg});
    chk("mem_en", {31'd0, mem_en}, {31'd0, e_en});
    chk("mem_we", {31'd0, mem_we}, {31'd0, e_we});
    chk("mem_addr", {22'd0, mem_addr}, e_addr);
    if (e_we) chk("mem_wdata", mem_wdata, lw);
    m_pv = m_fg;
    m_pf = m_fg && !fok;
    m_pd = (m_fg && fok) ? golden[fa / 4] : 32'h0;
    if (e_we) golden[la / 4] = lw;
    m_wait = (lr && !m_lg) ? m_wait + 1 : 0;
    m_core = m_run;
    if (ld) m_run = 1'b1;
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) step(1'b0, 32'h0, 1'b0, 32'h0, 32'h0, 1'b0);
  endtask

  // Asynchronous reset asserted mid-cycle, then released on a falling edge.
  task automatic do_reset();
    rst = 1'b0;
    #1;
    model_reset();
    chk("rst_fetch_valid", {31'd0, bus.fetch_valid}, 32'd0);
    chk("rst_core_rst_n", {31'd0, core_rst_n}, 32'd0);
    chk("rst_fetch_rdata", bus.fetch_rdata, 32'd0);
    chk("rst_fetch_gnt", {31'd0, bus.fetch_gnt}, {31'd0, 1'b0});
    bus.fetch_req = 1'b0; bus.ld_req = 1'b0; bus.ld_done = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
  endtask

  function automatic logic [31:0] rand_addr();
    int r;
    r = int'($urandom_range(0, 15));
    if (r == 0)      return 32'($urandom_range(0, 15) * 4 + $urandom_range(1, 3));
    else if (r == 1) return 32'(4 * DEPTH + $urandom_range(0, 63) * 4);
    else             return 32'($urandom_range(0, 15) * 4);
  endfunction

  initial begin
    logic [31:0] img [0:2];
    int          starve_at;
    bit          fr, lr;
    logic [31:0] fa, la, lw;

    img[0] = 32'h0050_0093; img[1] = 32'h00A0_0113; img[2] = 32'h0020_81B3;
    bus.fetch_req = 1'b0; bus.fetch_addr = 32'h0; bus.ld_req = 1'b0;
    bus.ld_addr = 32'h0; bus.ld_wdata = 32'h0; bus.ld_done = 1'b0;
    rst = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    chk("reset_core_rst_n", {31'd0, core_rst_n}, 32'd0);
    chk("reset_fetch_valid", {31'd0, bus.fetch_valid}, 32'd0);
    chk("reset_fetch_fault", {31'd0, bus.fetch_fault}, 32'd0);
    rst = 1'b1;

    // Boot image: three known words plus filler; fetch requested but locked out.
    for (int i = 0; i < 16; i++) begin
      lw = (i < 3) ? img[i] : $urandom;
      step(1'b1, 32'h0, 1'b1, 32'(i * 4), lw, 1'b0);
    end
    step(1'b0, 32'h0, 1'b0, 32'h0, 32'h0, 1'b1);
    idle(2);

    // Back-to-back fetches of the boot image.
    for (int i = 0; i < 3; i++) step(1'b1, 32'(i * 4), 1'b0, 32'h0, 32'h0, 1'b0);
    step(1'b0, 32'h0, 1'b0, 32'h0, 32'h0, 1'b0);
    chk("last_boot_word", bus.fetch_rdata, 32'h0020_81B3);

    // Misaligned and out-of-range fetches.
    step(1'b1, 32'h6, 1'b0, 32'h0, 32'h0, 1'b0);
    step(1'b1, 32'h1000, 1'b0, 32'h0, 32'h0, 1'b0);
    idle(1);

    // Starvation guard: loader must get through on the 9th losing cycle.
    starve_at = 0;
    for (int i = 1; i <= 11; i++) begin
      step(1'b1, 32'h4, (starve_at == 0), 32'h14, 32'h1234_5678, 1'b0);
      if (bus.ld_gnt && starve_at == 0) starve_at = i;
    end
    chk("starve_cycle", 32'(starve_at), 32'd9);
    idle(1);

    // Write then immediate read of the same word.
    step(1'b0, 32'h0, 1'b1, 32'h10, 32'hDEAD_BEEF, 1'b0);
    step(1'b1, 32'h10, 1'b0, 32'h0, 32'h0, 1'b0);
    step(1'b0, 32'h0, 1'b0, 32'h0, 32'h0, 1'b0);
    chk("hazard_rdata", bus.fetch_rdata, 32'hDEAD_BEEF);

    // Reset between a grant and its valid; then BOOT again until ld_done.
    step(1'b1, 32'h8, 1'b0, 32'h0, 32'h0, 1'b0);
    do_reset();
    for (int i = 0; i < 4; i++) step(1'b1, 32'h0, 1'b0, 32'h0, 32'h0, 1'b0);
    step(1'b1, 32'h0, 1'b0, 32'h0, 32'h0, 1'b1);
    idle(2);

    // Randomized traffic with requesters holding until granted.
    fr = 1'b0; lr = 1'b0; fa = 32'h0; la = 32'h0; lw = 32'h0;
    for (int i = 0; i < 400; i++) begin
      if (!fr || m_fg) begin
        fr = ($urandom_range(0, 3) != 0);
        fa = rand_addr();
      end
      if (!lr || m_lg) begin
        lr = ($urandom_range(0, 3) == 0);
        la = rand_addr();
        lw = $urandom;
      end
      step(fr, fa, lr, la, lw, ($urandom_range(0, 31) == 0));
    end
    idle(2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/imem_arbiter.md
Name: imem_arbiter

Overview:
- Owns the single port of the 1024x32 instruction memory and shares it between the IF-stage fetch requester and the program loader/debug write requester.
- Sequences boot: holds the core in reset while the loader fills memory, then releases it and arbitrates fetch against late loader writes with a starvation guard.
- Sits between IF stage, loader, and a synchronous-read memory macro; flags misaligned and out-of-range fetches.

Parameters:
- DEPTH, 1024, memory words; index width AW = clog2(DEPTH) = 10
- MAX_WAIT, 8, consecutive cycles a loader request may lose to fetch before it is forced through (range 1..255)

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous, active-low reset
- fetch_req  in  1  IF stage requests an instruction word
- fetch_addr  in  32  byte address
- fetch_gnt  out  1  combinational, same cycle; fetch accepted this cycle
- fetch_valid  out  1  registered; fetch_rdata valid
- fetch_rdata  out  32  instruction word; 0 on fault
- fetch_fault  out  1  registered, with fetch_valid; misaligned or out of range
- ld_req  in  1  loader write request
- ld_addr  in  32  byte address
- ld_wdata  in  32  write data
- ld_gnt  out  1  combinational; write performed this cycle
- ld_done  in  1  single-cycle pulse; loader finished boot image
- core_rst_n  out  1  registered; active-low reset to pipeline
- mem_en  out  1  memory port enable
- mem_we  out  1  memory write enable
- mem_addr  out  AW  word index = addr[AW+1:2]
- mem_wdata  out  32  write data
- mem_rdata  in  32  memory read data, one cycle after mem_en with !mem_we

Behaviour:
- Reset (rst=0, asynchronous): state=BOOT, core_rst_n=0, fetch_valid=0, fetch_fault=0, fetch_rdata=0, wait_cnt=0. Combinational grants and mem_* follow the BOOT rules. An in-flight read is dropped: no fetch_valid after rst deasserts.
- States:
  - BOOT: only the loader is serviced; fetch_gnt=0. ld_gnt=ld_req whenever the loader address is valid.
  - RUN: arbitration as below.
- Transitions: BOOT->RUN on ld_done. core_rst_n rises the cycle after the transition. RUN has no exit except rst. ld_done in RUN is ignored.
- Address validity: fetch_addr[1:0]!=0 or fetch_addr>=4*DEPTH means fault.
  - A faulting fetch is still granted but does not drive mem_en.
  - Next cycle: fetch_valid=1, fetch_fault=1, fetch_rdata=0.
  - An invalid loader address is granted and dropped (no write).
- RUN arbitration:
  - Default: fetch wins.
  - wait_cnt increments each cycle ld_req=1 and ld_gnt=0, and clears on ld_gnt or when ld_req=0.
  - When wait_cnt==MAX_WAIT, the loader wins that cycle and fetch_gnt=0.
  - Only one grant per cycle.
- Memory drive:
  - Granted valid fetch: mem_en=1, mem_we=0.
  - Granted valid write: mem_en=1, mem_we=1, mem_wdata=ld_wdata.
  - Otherwise mem_en=0, mem_we=0, mem_addr=0.
- Read latency: exactly 1 cycle. A grant at cycle N gives fetch_valid=1 at N+1 with fetch_rdata=mem_rdata.
  - Back-to-back grants give a valid every cycle.
  - fetch_valid=0 in any cycle with no prior grant.
- Same-address hazard: a write granted at N followed by a fetch granted at N+1 returns the new data, since the memory is write-then-read.
- Requesters must hold req, addr and wdata stable until granted.

Decomposition:
- Shared package imem_pkg:
  - DEPTH and AW constants.
  - State enum {BOOT, RUN}.
  - Function addr_ok(addr) for the alignment and range check.
- Natural sub-module: imem_starve_ctr, the MAX_WAIT saturating wait counter with clear. Arbitration, FSM and read pipeline stay in the top.

Test Plan:
- Reset then 3 loader writes (0x0<-0x00500093, 0x4<-0x00A00113, 0x8<-0x002081B3), then ld_done:
  - ld_gnt=1 each cycle; fetch_gnt=0 throughout BOOT.
  - core_rst_n=1 two cycles after ld_done.
- RUN, fetch 0x0, 0x4, 0x8 back-to-back -> fetch_valid on three consecutive cycles with data 0x00500093, 0x00A00113, 0x002081B3; fault=0.
- Fetch 0x6 and fetch 0x1000 -> fetch_valid=1, fetch_fault=1, fetch_rdata=0, mem_en=0 on the grant cycle.
- Continuous fetch_req plus ld_req held (MAX_WAIT=8) -> ld_gnt on the 9th cycle, fetch_gnt=0 that cycle; fetch resumes the next cycle.
- Write 0x10<-0xDEADBEEF granted at N, fetch 0x10 granted at N+1 -> fetch_rdata=0xDEADBEEF at N+2.
- Assert rst=0 between a grant and its valid in RUN -> fetch_valid=0, core_rst_n=0, state BOOT immediately; after release, fetch_gnt=0 until ld_done.
